// File: rtl/lock_pkg.sv
// Shared types and constants for the lock sequencer.
// Build option: define LOCK_CONFIRM_EN to require a new code to be entered
// twice (NEW_CONFIRM state) before it is written to the profile store.
package lock_pkg;

   localparam int DIGITS = 4;
   localparam int PW_W   = 16;
   localparam int TMR_W  = 16;

   localparam logic [3:0] KEY_ENTER  = 4'hA;
   localparam logic [3:0] KEY_CLEAR  = 4'hB;
   localparam logic [3:0] KEY_CHANGE = 4'hC;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_CHECK,
      ST_UNLOCKED,
      ST_NEW_ENTRY,
`ifdef LOCK_CONFIRM_EN
      ST_NEW_CONFIRM,
`endif
      ST_WRITE,
      ST_LOCKOUT
   } state_t;

   // Codes 0..9 are digits; everything above is a command or ignored.
   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by every timed state of the lock sequencer.
// A one-cycle start pulse loads load_val; done is high during the last of
// the load_val cycles that follow the start (load_val must be >= 1), so the
// owner leaves its state on the edge at which done is seen.
module lock_timer
   import lock_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [TMR_W-1:0] load_val,
   output logic             done
);

   logic [TMR_W-1:0] cnt;

   // The start cycle itself is the first counted cycle, hence load_val - 1.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (start)
         cnt <= load_val - TMR_W'(1);
      else if (cnt != '0)
         cnt <= cnt - TMR_W'(1);
   end

   assign done = start ? (load_val == TMR_W'(1)) : (cnt == TMR_W'(1));

endmodule

// File: rtl/lock_sequencer.sv
// Keypad-facing controller of the digital lock: builds 4-digit BCD codes,
// drives the profile store, times the match check, produces the unlock
// pulse, counts failures with timed lockout and sequences password change.
// Build option: define LOCK_CONFIRM_EN to add the NEW_CONFIRM step.
//
// Key strobe: key_valid_i is a one-cycle strobe that qualifies key_code_i;
// there is no back-pressure, keys that arrive while busy_o / locked_out_o
// are high (or on a timer-expiry edge) are simply dropped.
module lock_sequencer
   import lock_pkg::*;
#(
   parameter int MAX_FAIL       = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int UNLOCK_CYCLES  = 500,
   parameter int CHECK_LAT      = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            key_valid_i,
   input  logic [3:0]      key_code_i,
   input  logic [3:0]      profile_sel_i,
   input  logic            match_i,
   output logic [PW_W-1:0] store_pw_o,
   output logic [3:0]      store_prof_o,
   output logic            store_wr_o,
   output logic            unlock_o,
   output logic            locked_out_o,
   output logic [3:0]      fail_cnt_o,
   output logic            busy_o
);

   localparam logic [TMR_W-1:0] LAT_C     = TMR_W'(CHECK_LAT);
   localparam logic [TMR_W-1:0] UNLOCK_C  = TMR_W'(UNLOCK_CYCLES);
   localparam logic [TMR_W-1:0] LOCKOUT_C = TMR_W'(LOCKOUT_CYCLES);
   localparam logic [3:0]       MAX_C     = 4'(MAX_FAIL);
   localparam logic [2:0]       DIGITS_C  = 3'(DIGITS);

   state_t            state;
   logic [PW_W-1:0]   code_buf;
   logic [2:0]        dig_cnt;
   logic [PW_W-1:0]   ent_buf;
   logic [2:0]        ent_cnt;
   logic [3:0]        fail_inc;
   logic              tmr_start;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_done;
   logic              key_digit;
   logic              key_enter;
   logic              key_clear;
   logic              key_change;
`ifdef LOCK_CONFIRM_EN
   logic [PW_W-1:0]   saved_code;
`endif

   assign key_digit  = key_valid_i && is_digit(key_code_i);
   assign key_enter  = key_valid_i && (key_code_i == KEY_ENTER);
   assign key_clear  = key_valid_i && (key_code_i == KEY_CLEAR);
   assign key_change = key_valid_i && (key_code_i == KEY_CHANGE);
   assign fail_inc   = fail_cnt_o + 4'd1;
   assign store_pw_o = code_buf;

   lock_timer u_timer (
      .clk      (clk),
      .rst      (rst),
      .start    (tmr_start),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Digit-entry datapath shared by all entry states: shift in up to four
   // digits, clear on KEY_CLEAR, hold otherwise.
   always_comb begin
      ent_buf = code_buf;
      ent_cnt = dig_cnt;
      if (key_digit && (dig_cnt < DIGITS_C)) begin
         ent_buf = {code_buf[PW_W-5:0], key_code_i};
         ent_cnt = dig_cnt + 3'd1;
      end else if (key_clear) begin
         ent_buf = '0;
         ent_cnt = '0;
      end
   end

   // Sequencer FSM with registered outputs and timer start requests.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         code_buf     <= '0;
         dig_cnt      <= '0;
         store_prof_o <= '0;
         store_wr_o   <= 1'b0;
         unlock_o     <= 1'b0;
         locked_out_o <= 1'b0;
         fail_cnt_o   <= '0;
         busy_o       <= 1'b0;
         tmr_start    <= 1'b0;
         tmr_val      <= '0;
`ifdef LOCK_CONFIRM_EN
         saved_code   <= '0;
`endif
      end else begin
         tmr_start <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (key_digit) begin
                  state        <= ST_ENTRY;
                  code_buf     <= {{(PW_W-4){1'b0}}, key_code_i};
                  dig_cnt      <= 3'd1;
                  store_prof_o <= profile_sel_i;
               end
            end
            ST_ENTRY: begin
               code_buf <= ent_buf;
               dig_cnt  <= ent_cnt;
               if (key_enter) begin
                  if (dig_cnt == DIGITS_C) begin
                     state     <= ST_CHECK;
                     busy_o    <= 1'b1;
                     tmr_start <= 1'b1;
                     tmr_val   <= LAT_C;
                  end else begin
                     // A short entry is a failed attempt without a store lookup.
                     code_buf   <= '0;
                     dig_cnt    <= '0;
                     fail_cnt_o <= fail_inc;
                     if (fail_inc == MAX_C) begin
                        state        <= ST_LOCKOUT;
                        locked_out_o <= 1'b1;
                        tmr_start    <= 1'b1;
                        tmr_val      <= LOCKOUT_C;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end
            end
            ST_CHECK: begin
               if (tmr_done) begin
                  busy_o   <= 1'b0;
                  code_buf <= '0;
                  dig_cnt  <= '0;
                  if (match_i) begin
                     fail_cnt_o <= '0;
                     state      <= ST_UNLOCKED;
                     unlock_o   <= 1'b1;
                     tmr_start  <= 1'b1;
                     tmr_val    <= UNLOCK_C;
                  end else begin
                     fail_cnt_o <= fail_inc;
                     if (fail_inc == MAX_C) begin
                        state        <= ST_LOCKOUT;
                        locked_out_o <= 1'b1;
                        tmr_start    <= 1'b1;
                        tmr_val      <= LOCKOUT_C;
                     end else begin
                        state <= ST_IDLE;
                     end
                  end
               end
            end
            ST_UNLOCKED: begin
               // Expiry beats a simultaneous change key.
               if (tmr_done) begin
                  unlock_o <= 1'b0;
                  state    <= ST_IDLE;
               end else if (key_change) begin
                  unlock_o <= 1'b0;
                  state    <= ST_NEW_ENTRY;
               end
            end
            ST_NEW_ENTRY: begin
               code_buf <= ent_buf;
               dig_cnt  <= ent_cnt;
               if (key_enter && (dig_cnt == DIGITS_C)) begin
`ifdef LOCK_CONFIRM_EN
                  saved_code <= code_buf;
                  code_buf   <= '0;
                  dig_cnt    <= '0;
                  state      <= ST_NEW_CONFIRM;
`else
                  state      <= ST_WRITE;
                  store_wr_o <= 1'b1;
                  busy_o     <= 1'b1;
                  tmr_start  <= 1'b1;
                  tmr_val    <= LAT_C;
`endif
               end
            end
`ifdef LOCK_CONFIRM_EN
            ST_NEW_CONFIRM: begin
               code_buf <= ent_buf;
               dig_cnt  <= ent_cnt;
               if (key_enter && (dig_cnt == DIGITS_C)) begin
                  if (code_buf == saved_code) begin
                     state      <= ST_WRITE;
                     store_wr_o <= 1'b1;
                     busy_o     <= 1'b1;
                     tmr_start  <= 1'b1;
                     tmr_val    <= LAT_C;
                  end else begin
                     code_buf <= '0;
                     dig_cnt  <= '0;
                     state    <= ST_IDLE;
                  end
               end
            end
`endif
            ST_WRITE: begin
               if (tmr_done) begin
                  store_wr_o <= 1'b0;
                  busy_o     <= 1'b0;
                  code_buf   <= '0;
                  dig_cnt    <= '0;
                  state      <= ST_IDLE;
               end
            end
            ST_LOCKOUT: begin
               if (tmr_done) begin
                  locked_out_o <= 1'b0;
                  fail_cnt_o   <= '0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
